bsg_chip_reset_sequencer: RTL and testbench
===========================================

BSG_CHIP_RESET_SEQUENCER -- requirements
Module: bsg_chip_reset_sequencer

Interface
REQ-001 Parameter hold_cycles_p, default 16: cycles both resets stay asserted after a release request; legal range 1..65535.
REQ-002 Parameter stagger_cycles_p, default 4: cycles between core_reset_o release and link_reset_o release; legal range 1..65535.
REQ-003 clk_i  input  1: the single clock; all state is on its rising edge.
REQ-004 reset_n_i  input  1: asynchronous, active-low reset.
REQ-005 tag_new_i  input  1: one-cycle strobe from the upstream bsg_tag_client recv_new_r_o; the payload is valid in that cycle.
REQ-006 tag_reset_i  input  1: reset bit of the tag payload; 1 = assert request, 0 = release request.
REQ-007 core_reset_o  output  1: registered, active-high reset for core logic.
REQ-008 link_reset_o  output  1: registered, active-high reset for IO/mem link logic.
REQ-009 busy_o  output  1: high while a release sequence is in progress.
REQ-010 release_count_o  output  8: number of completed release sequences (see Configuration).

Function
REQ-011 The FSM SHALL have four states: ASSERTED, HOLD, STAGGER, RUN.
REQ-012 Outputs by state: ASSERTED and HOLD -> core=1, link=1; STAGGER -> core=0, link=1; RUN -> core=0, link=0.
REQ-013 busy_o SHALL be 1 exactly in HOLD and STAGGER; it is registered with the state, with no combinational path from the inputs.
REQ-014 Requests SHALL be sampled only in cycles where tag_new_i=1; tag_reset_i is ignored otherwise.
REQ-015 ASSERTED + release request -> HOLD, with a 16-bit down-counter loaded with hold_cycles_p-1; an assert request is ignored.
REQ-016 HOLD: the counter decrements each cycle; when it reads 0 -> STAGGER, with the counter loaded with stagger_cycles_p-1.
REQ-017 STAGGER: the counter decrements each cycle; when it reads 0 -> RUN.
REQ-018 RUN + assert request -> ASSERTED; a release request is ignored.
REQ-019 HOLD or STAGGER + assert request SHALL abort to ASSERTED on the next edge, taking priority over the counter reaching 0 in the same cycle.
REQ-020 HOLD or STAGGER + release request SHALL be ignored; the counter does not restart.
REQ-021 Latency: a release request sampled at edge t gives core_reset_o=0 from edge t+hold_cycles_p+1 and link_reset_o=0 from edge t+hold_cycles_p+stagger_cycles_p+1.
REQ-022 Latency: an assert request sampled at edge t gives core_reset_o=link_reset_o=1 from edge t+1.
REQ-023 link_reset_o SHALL never be 0 while core_reset_o is 1.

Reset
REQ-024 While reset_n_i=0: state=ASSERTED, core_reset_o=1, link_reset_o=1, busy_o=0, counter=0, release_count_o=0, all asynchronously.
REQ-025 Assertion of reset_n_i mid-sequence SHALL abandon the sequence immediately, without waiting for a clock edge.
REQ-026 After reset_n_i deasserts, the block SHALL stay in ASSERTED until it samples a release request.

Configuration
REQ-027 Macro BSG_CHIP_RESET_SEQ_COUNT_EN SHALL control the release counter.
REQ-028 When defined, release_count_o SHALL increment on every STAGGER->RUN transition, saturating at 255.
REQ-029 When undefined, release_count_o SHALL be tied to 0 and no counter flops are built; all other behaviour is identical.

Verification (hold_cycles_p=4, stagger_cycles_p=2 unless stated)
REQ-030 Reset, then a release request at edge 10 -> core_reset_o falls at edge 15, link_reset_o falls at edge 17, busy_o=1 on edges 11..16, count=1 (macro on).
REQ-031 In RUN, an assert request at edge 30 -> both resets 1 at edge 31; a release request at 40 -> core falls at 45, link falls at 47, count=2.
REQ-032 A release request at edge 10, then an assert request at edge 13 (HOLD) -> ASSERTED at 14 with core=1 and link=1 throughout; count is unchanged.
REQ-033 An assert request in the last STAGGER cycle -> ASSERTED with link_reset_o=1 throughout and core_reset_o back to 1 on the next edge; count is unchanged.
REQ-034 reset_n_i pulsed low mid-STAGGER -> core_reset_o=1 and count=0 asynchronously, before the next edge.
REQ-035 With hold_cycles_p=1, stagger_cycles_p=1: a release request at edge 5 -> core falls at 7, link falls at 8; 300 sequences -> count=255 with the macro defined, 0 without it.

Source files
------------

// File: rtl/bsg_chip_reset_sequencer.sv
// Staged chip reset release: core reset drops after a hold window, link reset
// drops after a further stagger window. Release counter built only when BSG_CHIP_RESET_SEQ_COUNT_EN is defined.
module bsg_chip_reset_sequencer #(
    parameter int hold_cycles_p    = 16,
    parameter int stagger_cycles_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       tag_new_i,
    input  logic       tag_reset_i,
    output logic       core_reset_o,
    output logic       link_reset_o,
    output logic       busy_o,
    output logic [7:0] release_count_o
);

    localparam logic [15:0] HOLD_LD    = 16'(hold_cycles_p - 1);
    localparam logic [15:0] STAGGER_LD = 16'(stagger_cycles_p - 1);

    typedef enum logic [1:0] {
        ST_ASSERTED,
        ST_HOLD,
        ST_STAGGER,
        ST_RUN
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_req_vld;
    logic        r_req_rst;
    logic        r_core;
    logic        r_link;
    logic        r_busy;

    logic w_assert_req;
    logic w_release_req;
    logic w_seq_done;

    // Tag payload is registered first so the FSM never sees a combinational input path.
    assign w_assert_req  = r_req_vld &  r_req_rst;
    assign w_release_req = r_req_vld & ~r_req_rst;
    assign w_seq_done    = (r_state == ST_STAGGER) && (r_cnt == 16'd0) && !w_assert_req;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_ASSERTED;
            r_cnt     <= 16'd0;
            r_req_vld <= 1'b0;
            r_req_rst <= 1'b0;
            r_core    <= 1'b1;
            r_link    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_req_vld <= tag_new_i;
            r_req_rst <= tag_reset_i;
            case (r_state)
                ST_ASSERTED: begin
                    if (w_release_req) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= HOLD_LD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HOLD, ST_STAGGER: begin
                    // An assert request wins over the counter expiring in the same cycle.
                    if (w_assert_req) begin
                        r_state <= ST_ASSERTED;
                        r_cnt   <= 16'd0;
                        r_core  <= 1'b1;
                        r_link  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (r_state == ST_HOLD) begin
                        r_state <= ST_STAGGER;
                        r_cnt   <= STAGGER_LD;
                        r_core  <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                        r_link  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_assert_req) begin
                        r_state <= ST_ASSERTED;
                        r_core  <= 1'b1;
                        r_link  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ASSERTED;
                    r_cnt   <= 16'd0;
                    r_core  <= 1'b1;
                    r_link  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset_o = r_core;
    assign link_reset_o = r_link;
    assign busy_o       = r_busy;

`ifdef BSG_CHIP_RESET_SEQ_COUNT_EN
    logic [7:0] r_rel_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rel_cnt <= 8'd0;
        end else if (w_seq_done && (r_rel_cnt != 8'hFF)) begin
            r_rel_cnt <= r_rel_cnt + 8'd1;
        end
    end

    assign release_count_o = r_rel_cnt;
`else
    logic w_unused;
    assign w_unused        = w_seq_done;
    assign release_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_bsg_chip_reset_sequencer.sv
// Bench for bsg_chip_reset_sequencer: two instances (4/2 and 1/1 cycle windows) driven
// in lockstep and compared each edge against a timeline model of the release sequence.
module tb_bsg_chip_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tag_new;
    logic       tag_reset;
    logic [1:0] core, link, busy;
    logic [7:0] cnt_o [2];

    int n_chk = 0;
    int n_err = 0;
    int e     = 0;

    // Reference timeline per instance: release sampled at s_m, abort effective at ab_m.
    int HH [2] = '{4, 1};
    int SS [2] = '{2, 1};
    int s_m [2];
    int ab_m [2];
    int cnt_m [2];
    bit act_m [2];

    always #5 clk = ~clk;

    bsg_chip_reset_sequencer #(.hold_cycles_p(4), .stagger_cycles_p(2)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .tag_new_i(tag_new), .tag_reset_i(tag_reset),
        .core_reset_o(core[0]), .link_reset_o(link[0]), .busy_o(busy[0]),
        .release_count_o(cnt_o[0]));

    bsg_chip_reset_sequencer #(.hold_cycles_p(1), .stagger_cycles_p(1)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .tag_new_i(tag_new), .tag_reset_i(tag_reset),
        .core_reset_o(core[1]), .link_reset_o(link[1]), .busy_o(busy[1]),
        .release_count_o(cnt_o[1]));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int k);
`ifdef BSG_CHIP_RESET_SEQ_COUNT_EN
        return cnt_m[k];
`else
        return (k < 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            act_m[k] = 1'b0; s_m[k] = 0; ab_m[k] = 0; cnt_m[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (act_m[k] && e >= ab_m[k]) act_m[k] = 1'b0;
            if (act_m[k] && e == s_m[k] + HH[k] + SS[k] + 1 && cnt_m[k] < 255) cnt_m[k]++;
        end
    endtask

    task automatic model_req(input bit nw, input bit rs);
        if (!nw) return;
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                if (act_m[k] && ab_m[k] > e + 1) ab_m[k] = e + 1;
            end else if (!act_m[k]) begin
                act_m[k] = 1'b1; s_m[k] = e; ab_m[k] = 32'h7fffffff;
            end
        end
    endtask

    task automatic check_all();
        int ec, el, eb;
        for (int k = 0; k < 2; k++) begin
            if (!act_m[k]) begin
                ec = 1; el = 1; eb = 0;
            end else begin
                ec = (e < s_m[k] + HH[k] + 1) ? 1 : 0;
                el = (e < s_m[k] + HH[k] + SS[k] + 1) ? 1 : 0;
                eb = (e >= s_m[k] + 1 && e <= s_m[k] + HH[k] + SS[k]) ? 1 : 0;
            end
            chk($sformatf("core[%0d]@%0d", k, e), int'(core[k]), ec);
            chk($sformatf("link[%0d]@%0d", k, e), int'(link[k]), el);
            chk($sformatf("busy[%0d]@%0d", k, e), int'(busy[k]), eb);
            chk($sformatf("count[%0d]@%0d", k, e), int'(cnt_o[k]), exp_cnt(k));
            chk($sformatf("order[%0d]@%0d", k, e), int'(core[k] & ~link[k]), 0);
        end
    endtask

    task automatic step(input bit nw, input bit rs);
        tag_new = nw; tag_reset = rs;
        @(posedge clk);
        e++;
        #1;
        model_edge();
        check_all();
        model_req(nw, rs);
    endtask

    task automatic run_to(input int target);
        while (e < target - 1) step(1'b0, 1'($urandom % 2));
    endtask

    task automatic do_reset();
        reset_n = 1'b0; tag_new = 1'b0; tag_reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        e = 0;
    endtask

    initial begin
        reset_n = 1'b0; tag_new = 1'b0; tag_reset = 1'b0;
        model_clear();
        do_reset();

        // Staged release, re-assert from RUN, aborts in HOLD and in the last STAGGER cycle.
        run_to(10); step(1'b1, 1'b0);
        run_to(30); step(1'b1, 1'b1);
        run_to(40); step(1'b1, 1'b0);
        run_to(52); step(1'b1, 1'b1);
        run_to(60); step(1'b1, 1'b0);
        run_to(63); step(1'b1, 1'b1);
        run_to(70); step(1'b1, 1'b0);
        run_to(76); step(1'b1, 1'b1);
        run_to(90); step(1'b1, 1'b0);
        run_to(96);

        // Asynchronous reset in the middle of dut_a's STAGGER window.
        #1 reset_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1 reset_n = 1'b1;
        e = 0;

        repeat (400) step(1'(($urandom % 4) == 0), 1'($urandom % 2));

        repeat (300) begin
            step(1'b1, 1'b0);
            repeat (7) step(1'b0, 1'b0);
            step(1'b1, 1'b1);
            step(1'b0, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
`ifdef BSG_CHIP_RESET_SEQ_COUNT_EN
            chk($sformatf("saturated[%0d]", k), int'(cnt_o[k]), 255);
`else
            chk($sformatf("saturated[%0d]", k), int'(cnt_o[k]), 0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
